// File: rtl/alu_mdu.sv
// Execution-stage ALU with an iterative shift-add multiplier and restoring divider.
// Simple ops finish in one cycle; MUL/DIV hold busy and own the HI register.
module alu_mdu #(
  parameter int WIDTH     = 32,
  parameter int MUL_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             ovf,
  output logic             illegal,
  output logic             div0
);

  localparam int CW = $clog2(MUL_STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(MUL_STEPS - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_MFHI = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // MUL: shifting multiplicand; DIV: dividend -> quotient
  logic [WIDTH-1:0] opb_q, opb_d;   // MUL: shifting multiplier;   DIV: divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d;   // MUL: partial product;       DIV: partial remainder
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d, ovf_q, ovf_d, illegal_q, illegal_d, div0_q, div0_d;

  logic [WIDTH-1:0] sum, diff, a_mag, b_mag, acc_step;
  logic [WIDTH:0]   rem_shift, trial;
  logic             slt;

  assign sum       = a + b;
  assign diff      = a - b;
  assign slt       = $signed(a) < $signed(b);
  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;
  assign acc_step  = acc_q + (opb_q[0] ? opa_q : '0);
  assign rem_shift = {acc_q, opa_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, opb_q};

  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path that skips it infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    zero_d    = zero_q;
    hi_d      = hi_q;
    result_d  = result_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    div0_d    = div0_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_neg_d = a[WIDTH-1];
          b_neg_d = b[WIDTH-1];
          opa_d   = a_mag;
          opb_d   = b_mag;
          acc_d   = '0;
          cnt_d   = '0;
          zero_d  = (b == '0);
          if (ALUop == OP_MUL) begin
            state_d = S_MUL;
          end else if (ALUop == OP_DIV) begin
            state_d = S_DIV;
          end else begin
            done_d    = 1'b1;
            ovf_d     = 1'b0;
            illegal_d = 1'b0;
            div0_d    = 1'b0;
            case (ALUop)
              OP_ADD: begin
                result_d = sum;
                ovf_d    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
              end
              OP_SUB: begin
                result_d = diff;
                ovf_d    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
              end
              OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, slt};
              OP_MFHI: result_d = hi_q;
              default: begin
                result_d  = '0;
                illegal_d = 1'b1;
              end
            endcase
          end
        end
      end

      S_MUL: begin
        acc_d = acc_step;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          result_d  = (a_neg_q ^ b_neg_q) ? -acc_step : acc_step;
          ovf_d     = 1'b0;
          illegal_d = 1'b0;
          div0_d    = 1'b0;
        end
      end

      S_DIV: begin
        // A zero divisor only burns the cycles so latency stays fixed.
        if (!zero_q) begin
          if (!trial[WIDTH]) begin
            acc_d = trial[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_shift[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = S_FIX;
      end

      S_FIX: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        ovf_d     = 1'b0;
        illegal_d = 1'b0;
        div0_d    = zero_q;
        if (zero_q) begin
          result_d = '1;
          hi_d     = a_neg_q ? -opa_q : opa_q;
        end else begin
          result_d = (a_neg_q ^ b_neg_q) ? -opa_q : opa_q;
          hi_d     = a_neg_q ? -acc_q : acc_q;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      zero_q    <= 1'b0;
      hi_q      <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      zero_q    <= zero_d;
      hi_q      <= hi_d;
      result_q  <= result_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      div0_q    <= div0_d;
    end
  end

  assign result  = result_q;
  assign done    = done_q;
  assign busy    = (state_q != S_IDLE);
  assign ovf     = ovf_q;
  assign illegal = illegal_q;
  assign div0    = div0_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed scenarios plus random ops checked
// against an arithmetic reference model with its own HI copy.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ALUop;
  logic [31:0] a, b;
  logic [31:0] result;
  logic        done, busy, ovf, illegal, div0;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] ref_hi;

  alu_mdu #(.WIDTH(32), .MUL_STEPS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUop(ALUop), .a(a), .b(b),
    .result(result), .done(done), .busy(busy), .ovf(ovf), .illegal(illegal), .div0(div0)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain signed arithmetic; returns expected latency in edges after acceptance.
  task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] er, output logic eo, output logic ei,
                       output logic ed, output int elat);
    longint sx, sy, t, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    er = '0; eo = 0; ei = 0; ed = 0; elat = 0;
    case (op)
      4'd0: begin t = sx + sy; er = 32'(t); eo = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'd1: begin t = sx - sy; er = 32'(t); eo = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'd2: er = (sx < sy) ? 32'd1 : 32'd0;
      4'd3: begin t = sx * sy; er = 32'(t); elat = 32; end
      4'd4: begin
        elat = 33;
        if (y == 32'd0) begin
          er = 32'hFFFF_FFFF; ed = 1; ref_hi = x;
        end else begin
          q = sx / sy; r = sx % sy;
          er = 32'(q); ref_hi = 32'(r);
        end
      end
      4'd5: er = ref_hi;
      default: ei = 1;
    endcase
  endtask

  // Issue one op; optionally pulse an ADD start 'inject' edges into a multi-cycle op.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int inject);
    logic [31:0] er;
    logic eo, ei, ed, busy_ok;
    int elat, cyc;
    model(op, x, y, er, eo, ei, ed, elat);
    @(negedge clk);
    start = 1'b1; ALUop = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; ALUop = 4'($urandom); a = $urandom; b = $urandom;
    cyc = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (cyc == inject) begin
        @(negedge clk);
        start = 1'b1; ALUop = 4'd0; a = 32'd1; b = 32'd2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(elat));
    if (elat > 0) check({tag, ".busy_held"}, {31'd0, busy_ok}, 32'd1);
    check({tag, ".result"}, result, er);
    check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
    check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, ei});
    check({tag, ".div0"}, {31'd0, div0}, {31'd0, ed});
    check({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic idle_cycle_done_low(input string tag);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n_done;
    logic [3:0] rop;
    rst_n = 1'b0; start = 1'b0; ALUop = '0; a = '0; b = '0; ref_hi = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.result", result, 32'd0);
    check("reset.flags", {26'd0, done, busy, ovf, illegal, div0, 1'b0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("mfhi_reset", 4'd5, 32'd0, 32'd0, -1);
    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, -1);
    idle_cycle_done_low("add_ovf");
    run_op("sub", 4'd1, 32'd5, 32'd7, -1);
    run_op("slt", 4'd2, 32'hFFFF_FFFF, 32'd1, -1);
    run_op("mul", 4'd3, 32'hFFFF_FFFD, 32'd7, -1);
    idle_cycle_done_low("mul");
    run_op("mfhi_after_mul", 4'd5, 32'd0, 32'd0, -1);
    run_op("div", 4'd4, 32'hFFFF_FFF9, 32'd2, -1);
    run_op("mfhi_after_div", 4'd5, 32'd0, 32'd0, -1);
    run_op("div_min", 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("mfhi_min", 4'd5, 32'd0, 32'd0, -1);
    run_op("div0", 4'd4, 32'h0000_1234, 32'd0, -1);
    run_op("mfhi_div0", 4'd5, 32'd0, 32'd0, -1);
    run_op("mul_inject", 4'd3, 32'h0001_0003, 32'hFFFF_0101, 10);
    run_op("div_inject", 4'd4, 32'd1000, 32'hFFFF_FFF9, 20);
    run_op("illegal9", 4'd9, 32'h1234_5678, 32'h1, -1);
    run_op("illegal15", 4'd15, 32'hDEAD_BEEF, 32'h5, -1);
    run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'd1, -1);

    // Reset in the middle of a DIV: outputs and HI must clear at once, no done afterwards.
    run_op("div_pre", 4'd4, 32'd77, 32'd5, -1);
    @(negedge clk);
    start = 1'b1; ALUop = 4'd4; a = 32'd100; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    check("rst_mid.result", result, 32'd0);
    check("rst_mid.flags", {26'd0, done, busy, ovf, illegal, div0, 1'b0}, 32'd0);
    ref_hi = '0;
    @(negedge clk); rst_n = 1'b1;
    n_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) n_done++;
    end
    check("rst_mid.no_done", 32'(n_done), 32'd0);
    run_op("rst_mid.mfhi", 4'd5, 32'd0, 32'd0, -1);

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 6));
      if (rop == 4'd6) rop = 4'($urandom_range(6, 15));
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, rand_operand(), rand_operand(),
             (rop == 4'd3 || rop == 4'd4) ? int'($urandom_range(0, 30)) : -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Execution-stage ALU with an integrated multi-cycle multiply/divide unit. It consumes the 4-bit ALUop produced by the instruction-decode ALU decoder, together with two 32-bit operands, and returns a registered result with a done pulse. ADD, SUB, SLT and MFHI complete in one cycle. MUL and DIV iterate and hold `busy` so the pipeline control can stall. The block owns the HI register that DIV writes and MFHI reads.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; only 32 is supported.
- `MUL_STEPS`, 32: multiply iterations; must equal WIDTH.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request strobe; sampled only when `busy`=0.
- `ALUop`  in  4  operation code (ALUop.vh): ADD=0, SUB=1, SLT=2, MUL=3, DIV=4, MFHI=5, XXX=15; all others treated as XXX.
- `a`, `b`  in  32  signed operands (rs, rt/imm); captured at accepted `start`.
- `result`  out  32  registered result; held until the next done.
- `done`  out  1  one-cycle pulse; `result` is valid while `done`=1 and afterwards.
- `busy`  out  1  high from the cycle after an accepted MUL/DIV start until its done.
- `ovf`  out  1  signed overflow of ADD/SUB; valid with `done`.
- `illegal`  out  1  ALUop not in {0..5}; valid with `done`.
- `div0`  out  1  DIV with `b`=0; valid with `done`.

## Operation
- States: IDLE, MUL, DIV, FIX.
  - IDLE + start + simple op (ADD/SUB/SLT/MFHI/XXX): compute, register the result, pulse `done`, remain in IDLE.
  - IDLE + start + MUL: go to MUL.
  - IDLE + start + DIV: go to DIV.
  - MUL: 32 iterations, then IDLE with `done`.
  - DIV: 32 iterations, then FIX.
  - FIX: 1 cycle, then IDLE with `done`.
- ADD/SUB: 32-bit wraparound result. `ovf` = operand signs match (ADD) or differ (SUB) and the result sign differs from `a`.
- SLT: `result` = {31'b0, signed(a) < signed(b)}. `ovf` = 0.
- MFHI: `result` = HI.
- XXX: `result` = 0, `illegal` = 1.
- MUL: shift-add on operand magnitudes; the sign is applied in the final step. `result` = low 32 bits of the signed product. HI is unchanged.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - FIX applies signs: quotient is negated if the operand signs differ; remainder takes the sign of `a`.
  - `result` = quotient; HI = remainder. HI is written in the same cycle as `done`.
- DIV boundary cases:
  - `b`=0: no iteration occurs but latency is unchanged. `result` = 0xFFFFFFFF, HI = `a`, `div0` = 1.
  - `a`=0x80000000, `b`=-1: `result` = 0x80000000, HI = 0.
- `start` while `busy`=1 is ignored: no capture, no effect on the operation in flight.
- `start` in the cycle that `done` pulses for a simple op is accepted normally, giving back-to-back operations.
- Reset mid-operation: the iteration is abandoned, state returns to IDLE, and no `done` is produced.

## Timing
- Reset values: `result`=0, `done`=0, `busy`=0, `ovf`=0, `illegal`=0, `div0`=0, HI=0, state=IDLE.
- Simple ops: `start` sampled at edge E0 → `done`=1 and `result` valid after E0, for one cycle. Latency is 1; throughput is 1 op/cycle.
- MUL: accepted at E0 → `busy`=1 after E0 through E32 → `done` after E32 (latency 32). `busy` drops in the same cycle `done` rises.
- DIV: accepted at E0 → `busy`=1 through E33 → `done` after E33 (latency 33, including FIX).
- `ovf`, `illegal`, `div0`:
  - Updated on every `done`.
  - Cleared to 0 where not applicable.
  - Hold their value between dones.
- Operands may change freely after acceptance; the block works only from its captured copies.

## Test plan
- Reset then ADD `a`=0x7FFFFFFF, `b`=1 → after 1 cycle: `result`=0x80000000, `ovf`=1, `done` pulses once.
- SUB `a`=5, `b`=7, then SLT `a`=-1, `b`=1 on consecutive cycles → results 0xFFFFFFFE and 1 on consecutive `done` pulses.
- MUL `a`=-3, `b`=7 → `busy` for 32 cycles, `result`=0xFFFFFFEB on `done` at cycle 32, HI unchanged (0).
- DIV `a`=-7, `b`=2, then MFHI → DIV `result`=0xFFFFFFFD at cycle 33; MFHI `result`=0xFFFFFFFF.
- DIV `b`=0 with `a`=0x1234 → `div0`=1, `result`=0xFFFFFFFF, then MFHI returns 0x1234.
- Boundary sequence:
  - ADD `start` pulsed mid-MUL → ignored; the MUL result is correct.
  - Assert `rst_n`=0 during a DIV → outputs and HI return to reset values immediately; no `done` appears.
  - ALUop=9 → `illegal`=1, `result`=0.
